// File: rtl/seq_counter.sv
// seq_counter: up/down run counter with a three-state controller.
// A run is launched from IDLE by start, steps toward a terminal value
// (lim_r when counting up, 0 when counting down) while en is high, then
// emits a single-cycle done pulse. abort ends a run early without done.
module seq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             start,
  input  logic             en,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] count_nx;
  logic             dir_r;
  logic             dir_nx;
  logic [WIDTH-1:0] lim_r;
  logic [WIDTH-1:0] lim_nx;
  logic [WIDTH-1:0] term;
  logic             at_term;

  // Terminal value depends on the direction captured at start, never on live inputs.
  assign term    = dir_r ? lim_r : '0;
  assign at_term = (count == term);

  // Next-state, next-count and run-parameter capture.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_nx = state;
    count_nx = count;
    dir_nx   = dir_r;
    lim_nx   = lim_r;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = COUNT;
          dir_nx   = sel;
          lim_nx   = limit;
          count_nx = sel ? '0 : limit;
        end
      end
      COUNT: begin
        // abort outranks terminal detect, which outranks en.
        if (abort) begin
          state_nx = IDLE;
        end else if (at_term) begin
          state_nx = DONE;
        end else if (en) begin
          count_nx = dir_r ? (count + ONE) : (count - ONE);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state <= IDLE;
      count <= '0;
      dir_r <= 1'b1;
      lim_r <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      dir_r <= dir_nx;
      lim_r <= lim_nx;
    end
  end

  assign busy = (state == COUNT) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_counter.sv
// Directed self-checking bench for seq_counter.
module tb_seq_counter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             sel;
  logic             start;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  seq_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .start (start),
    .en    (en),
    .abort (abort),
    .limit (limit),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare count, busy and done in one call.
  task automatic check_out(input string tag, input int exp_count, input bit exp_busy, input bit exp_done);
    check({tag, ".count"}, 32'(count), 32'(exp_count));
    check({tag, ".busy"},  32'(busy),  32'(exp_busy));
    check({tag, ".done"},  32'(done),  32'(exp_done));
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; start = 1'b0; en = 1'b0; abort = 1'b0; limit = '0;
    tick(); tick();
    reset = 1'b0;
    check_out("reset", 0, 1'b0, 1'b0);

    // Up run, limit 3: count 0,1,2,3 then DONE on the 5th edge from start.
    sel = 1'b1; limit = 8'd3; start = 1'b1; en = 1'b1;
    tick(); start = 1'b0;
    check_out("up.e1", 0, 1'b1, 1'b0);
    tick(); check_out("up.e2", 1, 1'b1, 1'b0);
    tick(); check_out("up.e3", 2, 1'b1, 1'b0);
    tick(); check_out("up.e4", 3, 1'b1, 1'b0);
    tick(); check_out("up.done", 3, 1'b1, 1'b1);
    tick(); check_out("up.idle", 3, 1'b0, 1'b0);
    tick(); check_out("up.hold", 3, 1'b0, 1'b0);

    // Down run, limit 4: count 4,3,2,1,0, then done, then idle.
    sel = 1'b0; limit = 8'd4; start = 1'b1;
    tick(); start = 1'b0;
    check_out("dn.e1", 4, 1'b1, 1'b0);
    tick(); check_out("dn.e2", 3, 1'b1, 1'b0);
    tick(); check_out("dn.e3", 2, 1'b1, 1'b0);
    tick(); check_out("dn.e4", 1, 1'b1, 1'b0);
    tick(); check_out("dn.e5", 0, 1'b1, 1'b0);
    tick(); check_out("dn.done", 0, 1'b1, 1'b1);
    tick(); check_out("dn.idle", 0, 1'b0, 1'b0);

    // Enable gap: limit 2, en low for 3 cycles at count 1.
    sel = 1'b1; limit = 8'd2; start = 1'b1; en = 1'b1;
    tick(); start = 1'b0;
    check_out("gap.e1", 0, 1'b1, 1'b0);
    tick(); check_out("gap.e2", 1, 1'b1, 1'b0);
    en = 1'b0;
    tick(); check_out("gap.h1", 1, 1'b1, 1'b0);
    tick(); check_out("gap.h2", 1, 1'b1, 1'b0);
    tick(); check_out("gap.h3", 1, 1'b1, 1'b0);
    en = 1'b1;
    tick(); check_out("gap.e3", 2, 1'b1, 1'b0);
    tick(); check_out("gap.done", 2, 1'b1, 1'b1);
    tick(); check_out("gap.idle", 2, 1'b0, 1'b0);

    // Abort at count 5 of a limit-10 up run, with start in the same cycle.
    sel = 1'b1; limit = 8'd10; start = 1'b1;
    tick(); start = 1'b0;
    check_out("ab.e1", 0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) tick();
    check_out("ab.c5", 5, 1'b1, 1'b0);
    abort = 1'b1; start = 1'b1;
    tick(); abort = 1'b0; start = 1'b0;
    check_out("ab.idle", 5, 1'b0, 1'b0);
    tick(); check_out("ab.hold", 5, 1'b0, 1'b0);

    // Abort outranks terminal detect: limit 1, abort while count is terminal.
    sel = 1'b1; limit = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); check_out("abt.term", 1, 1'b1, 1'b0);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check_out("abt.idle", 1, 1'b0, 1'b0);

    // limit 0 with en low: already terminal, DONE regardless of en.
    sel = 1'b1; limit = 8'd0; start = 1'b1; en = 1'b0;
    tick(); start = 1'b0;
    check_out("z.count", 0, 1'b1, 1'b0);
    tick(); check_out("z.done", 0, 1'b1, 1'b1);
    tick(); check_out("z.idle", 0, 1'b0, 1'b0);

    // sel/limit toggled mid-run; start during DONE ignored.
    sel = 1'b1; limit = 8'd3; start = 1'b1; en = 1'b1;
    tick(); start = 1'b0; sel = 1'b0; limit = 8'd1;
    check_out("tg.e1", 0, 1'b1, 1'b0);
    tick(); check_out("tg.e2", 1, 1'b1, 1'b0);
    tick(); check_out("tg.e3", 2, 1'b1, 1'b0);
    tick(); check_out("tg.e4", 3, 1'b1, 1'b0);
    tick(); check_out("tg.done", 3, 1'b1, 1'b1);
    start = 1'b1; sel = 1'b1; limit = 8'd5;
    tick(); start = 1'b0;
    check_out("tg.idle", 3, 1'b0, 1'b0);
    tick(); check_out("tg.hold", 3, 1'b0, 1'b0);

    // Reset mid-run at count 7 of a down run, start asserted with reset.
    sel = 1'b0; limit = 8'd10; start = 1'b1; en = 1'b1;
    tick(); start = 1'b0;
    check_out("rs.e1", 10, 1'b1, 1'b0);
    tick(); tick(); tick();
    check_out("rs.c7", 7, 1'b1, 1'b0);
    reset = 1'b1; start = 1'b1;
    tick(); reset = 1'b0; start = 1'b0;
    check_out("rs.after", 0, 1'b0, 1'b0);
    tick(); check_out("rs.idle", 0, 1'b0, 1'b0);

    // After reset the run defaults are restored: a limit-0 up run still works.
    sel = 1'b1; limit = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); check_out("post.done", 0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
